// File: rtl/slave_pkg.sv
// Shared link definitions: receiver FSM states and the default burst shape
// agreed between master and slave.
package slave_pkg;

  typedef enum logic {
    RECV = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam int unsigned LINK_DATA_W    = 3;
  localparam int unsigned LINK_BURST_LEN = 3;
  localparam logic [8:0]  LINK_EXP_SEQ   = 9'b111_101_110;
  localparam logic [7:0]  LINK_STALL_PAT = 8'h00;

endpackage

// File: rtl/slave_if.sv
// Valid/ready data link between the burst master and the slave checker.
interface slave_if import slave_pkg::*; #(
  parameter int unsigned DATA_W = LINK_DATA_W
) ();

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/slave_stall_gen.sv
// Free-running backpressure pattern: rotates right each clock and exposes the
// bit that will sit in position 0 after the coming edge.
module slave_stall_gen import slave_pkg::*; #(
  parameter logic [7:0] STALL_PAT = LINK_STALL_PAT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic stall_nxt_o
);

  logic [7:0] stall_q;
  logic [7:0] stall_d;

  assign stall_d     = {stall_q[0], stall_q[7:1]};
  assign stall_nxt_o = stall_d[0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_q <= STALL_PAT;
    end else begin
      stall_q <= stall_d;
    end
  end

endmodule

// File: rtl/slave.sv
// Link endpoint: accepts fixed-length bursts, checks them against EXP_SEQ,
// throttles with a rotating stall pattern and flags handshake violations.
module slave import slave_pkg::*; #(
  parameter int unsigned                   DATA_W    = LINK_DATA_W,
  parameter int unsigned                   BURST_LEN = LINK_BURST_LEN,
  parameter logic [DATA_W*BURST_LEN-1:0]   EXP_SEQ   = LINK_EXP_SEQ,
  parameter logic [7:0]                    STALL_PAT = LINK_STALL_PAT
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  slave_if.slave                       link,
  output logic                         rx_vld,
  output logic [DATA_W-1:0]            rx_word,
  output logic [$clog2(BURST_LEN)-1:0] rx_idx,
  output logic                         burst_done,
  output logic                         burst_err,
  output logic [7:0]                   burst_cnt,
  output logic                         proto_err
);

  localparam int unsigned      IDX_W    = $clog2(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_acc_q, err_acc_d;
  logic              ready_q, ready_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              rx_vld_q;
  logic [DATA_W-1:0] rx_word_q;
  logic [IDX_W-1:0]  rx_idx_q;
  logic              hold_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              proto_q, proto_d;
  logic              stall_nxt;
  logic              xfer;
  logic              mismatch;
  logic [DATA_W-1:0] exp_word [BURST_LEN];

  // Word 0 of the expected burst lives in the MSBs of EXP_SEQ.
  generate
    for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_exp
      assign exp_word[gi] = EXP_SEQ[(BURST_LEN-1-gi)*DATA_W +: DATA_W];
    end
  endgenerate

  slave_stall_gen #(
    .STALL_PAT (STALL_PAT)
  ) u_stall_gen (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .stall_nxt_o (stall_nxt)
  );

  assign xfer     = link.valid && ready_q;
  assign mismatch = (link.data != exp_word[idx_q]);

  // A master that raised valid while stalled must hold valid and data.
  assign proto_d = proto_q | (hold_q && (!link.valid || (link.data != hold_data_q)));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= RECV;
      idx_q       <= '0;
      err_acc_q   <= 1'b0;
      ready_q     <= 1'b0;
      burst_cnt_q <= '0;
      rx_vld_q    <= 1'b0;
      rx_word_q   <= '0;
      rx_idx_q    <= '0;
      hold_q      <= 1'b0;
      hold_data_q <= '0;
      proto_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_acc_q   <= err_acc_d;
      ready_q     <= ready_d;
      burst_cnt_q <= burst_cnt_d;
      rx_vld_q    <= xfer;
      if (xfer) begin
        rx_word_q <= link.data;
        rx_idx_q  <= idx_q;
      end
      hold_q      <= link.valid && !ready_q;
      hold_data_q <= link.data;
      proto_q     <= proto_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_acc_d   = err_acc_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      RECV: begin
        if (xfer) begin
          err_acc_d = err_acc_q | mismatch;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d     = RECV;
        err_acc_d   = 1'b0;
        burst_cnt_d = burst_cnt_q + 8'd1;
      end
      default: state_d = RECV;
    endcase
    // Registered ready looks one edge ahead so the DONE bubble is always closed.
    ready_d = (state_d == RECV) && !stall_nxt;
  end

  always_comb begin
    burst_done = 1'b0;
    burst_err  = 1'b0;
    if (state_q == DONE) begin
      burst_done = 1'b1;
      burst_err  = err_acc_q;
    end
  end

  assign link.ready = ready_q;
  assign rx_vld     = rx_vld_q;
  assign rx_word    = rx_word_q;
  assign rx_idx     = rx_idx_q;
  assign burst_cnt  = burst_cnt_q;
  assign proto_err  = proto_q;

endmodule

// File: doc/slave.md
# slave

Receiving end of the 3-bit valid/ready handshake link. Accepts fixed-length bursts from the master, throttles with a programmable backpressure pattern, and checks each burst word by word against an expected sequence. Reports per-word receive strobes, end-of-burst status and sticky protocol violations. Sits at the link endpoint and serves as the bench-side checker for master-side work.

## Interface
- DATA_W, 3, width of data
- BURST_LEN, 3, words per burst (≥2)
- EXP_SEQ, {3'b111,3'b101,3'b110}, expected burst; word 0 in the MSBs
- STALL_PAT, 8'h00, backpressure pattern; bit set = ready low that cycle
- sys_clk  input  1  clock, all logic on rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- valid  input  1  master data valid
- data  input  DATA_W  master data
- ready  output  1  slave ready, registered
- rx_vld  output  1  one-cycle strobe per accepted word
- rx_word  output  DATA_W  accepted word
- rx_idx  output  $clog2(BURST_LEN)  position of rx_word in burst
- burst_done  output  1  one-cycle pulse after last word of burst
- burst_err  output  1  valid with burst_done: any word mismatched EXP_SEQ
- burst_cnt  output  8  completed bursts, wraps 255→0
- proto_err  output  1  sticky protocol violation

## Operation
- Transfer = valid && ready at a rising edge; no other event moves state.
- FSM states RECV, DONE. Reset → RECV, idx=0.
- RECV: each transfer captures data to rx_word, idx to rx_idx, compares against EXP_SEQ word idx, ORs mismatch into err_acc, idx+1. Transfer at idx=BURST_LEN-1 → DONE, idx→0.
- DONE: exactly one cycle; ready=0, burst_done=1, burst_err=err_acc including last word; burst_cnt+1; err_acc cleared; → RECV.
- Stall register: 8-bit, reset to STALL_PAT, rotates right one bit every clock, free-running in both states.
- ready register next value = (next state is RECV) && !(next stall bit 0).
- proto_err set (sticky until reset) when, in a cycle with valid=1 and ready=0, the next cycle has valid=0 or data changed. Does not abort or alter the burst.
- valid low while ready high: no transfer, ready keeps following stall pattern.
- Reset mid-burst: partial burst discarded, no burst_done, burst_cnt cleared.

## Timing
- Reset values: ready=0, rx_vld=0, rx_word=0, rx_idx=0, burst_done=0, burst_err=0, burst_cnt=0, proto_err=0.
- ready is a flop; never combinationally dependent on valid or data.
- With STALL_PAT=0, ready=1 from first edge after reset release.
- rx_vld/rx_word/rx_idx: registered, asserted the cycle after the transfer edge.
- Last-word transfer at edge k: during cycle after k, rx_vld=1 (idx BURST_LEN-1), burst_done=1, burst_err valid, ready=0; burst_cnt shows +1 the following cycle.
- Back-to-back bursts with no stall: BURST_LEN+1 cycles per burst (one DONE bubble).
- burst_cnt 8'hFF + 1 → 8'h00, no flag.

## Structure
- Shared package: state enum (RECV, DONE), default EXP_SEQ and burst-length constants shared with the master.
- One sub-module natural: slave_stall_gen (rotating STALL_PAT register, outputs next stall bit).
- Compare, index counter, FSM, protocol monitor in the top module.

## Test plan
- Defaults, master sends 111,101,110 with valid held → rx_vld three times with rx_idx 0,1,2; burst_done=1, burst_err=0; burst_cnt=1.
- Second word sent as 100 → burst_done with burst_err=1; next clean burst gives burst_err=0.
- STALL_PAT=8'b0000_0101, valid held with stable data → ready low on pattern bits, all three words accepted once each, no duplicates, proto_err=0.
- Master drops valid (or changes data 101→011) while ready=0 → proto_err=1 and stays 1 through later clean bursts until sys_rst_n low.
- 256 clean bursts → burst_cnt returns to 0; 257th → 1.
- sys_rst_n pulsed low after word 1 of a burst → all outputs at reset values asynchronously; new full burst completes normally with burst_err=0, burst_cnt=1.
